param_sync_fifo: RTL and testbench

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/param_sync_fifo.sv | 110 +++++++++++
 tb/tb_param_sync_fifo.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with registered read data, occupancy count,
// registered status flags and sticky overflow/underflow flags.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   flush               sync clear of contents and error flags
//   write_enb, datain   write request and data
//   read_enb            read request
//   dataout, rd_valid   registered read data, one-cycle valid pulse
//   count               occupancy 0..DEPTH
//   full, empty         status flags
//   almost_full         count >= AF_LEVEL
//   almost_empty        count <= AE_LEVEL
//   overflow, underflow sticky error flags
module param_sync_fifo #(
  parameter int DATA_W   = 4,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              write_enb,
  input  logic              read_enb,
  input  logic [DATA_W-1:0] datain,
  output logic [DATA_W-1:0] dataout,
  output logic              rd_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count_nxt;
  logic              rd_acc;
  logic              wr_acc;

  // A read frees a slot in the same cycle, so a full FIFO can
  // still accept a write when a read is accepted alongside it.
  assign rd_acc = read_enb && !empty;
  assign wr_acc = write_enb && (!full || rd_acc);

  always_comb begin
    count_nxt = count;
    if (flush)
      count_nxt = '0;
    else if (wr_acc && !rd_acc)
      count_nxt = count + CW'(1);
    else if (rd_acc && !wr_acc)
      count_nxt = count - CW'(1);
  end

  // Storage carries no reset; entries beyond count are stale.
  always_ff @(posedge clk) begin
    if (wr_acc && !flush)
      mem[wr_ptr] <= datain;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      dataout      <= '0;
      rd_valid     <= 1'b0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      count        <= count_nxt;
      full         <= (count_nxt == CW'(DEPTH));
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= CW'(AF_LEVEL));
      almost_empty <= (count_nxt <= CW'(AE_LEVEL));
      if (flush) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        rd_valid  <= 1'b0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        rd_valid <= rd_acc;
        if (wr_acc)
          wr_ptr <= wr_ptr + AW'(1);
        if (rd_acc) begin
          dataout <= mem[rd_ptr];
          rd_ptr  <= rd_ptr + AW'(1);
        end
        if (write_enb && !wr_acc)
          overflow <= 1'b1;
        if (read_enb && empty)
          underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo at default parameters.
// Expected values are hand-derived from the FIFO behaviour.
module tb_param_sync_fifo;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       write_enb;
  logic       read_enb;
  logic [3:0] datain;
  logic [3:0] dataout;
  logic       rd_valid;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;
  logic       underflow;

  int n_chk;
  int n_pass;

  param_sync_fifo dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .write_enb    (write_enb),
    .read_enb     (read_enb),
    .datain       (datain),
    .dataout      (dataout),
    .rd_valid     (rd_valid),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs,
                     input int exp);
    n_chk++;
    if (obs == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_enb = 1'b0;
    read_enb  = 1'b0;
    flush     = 1'b0;
  endtask

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    datain    = '0;
    idle();

    // reset state
    tick();
    tick();
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_af", int'(almost_full), 0);
    chk("rst_ae", int'(almost_empty), 1);
    chk("rst_dout", int'(dataout), 0);
    chk("rst_rdv", int'(rd_valid), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_udf", int'(underflow), 0);
    rst_n = 1'b1;
    tick();

    // fill 0x1..0xF,0x0
    write_enb = 1'b1;
    for (int i = 0; i < 16; i++) begin
      datain = 4'(i + 1);
      tick();
      chk("fill_count", int'(count), i + 1);
      chk("fill_af", int'(almost_full), int'(i + 1 >= 14));
      chk("fill_ae", int'(almost_empty), int'(i + 1 <= 2));
      chk("fill_full", int'(full), int'(i + 1 == 16));
      chk("fill_empty", int'(empty), 0);
    end
    datain = 4'h7;
    tick();
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_count", int'(count), 16);
    chk("ovf_full", int'(full), 1);

    // drain 16
    write_enb = 1'b0;
    read_enb  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("drain_dout", int'(dataout), (i + 1) % 16);
      chk("drain_rdv", int'(rd_valid), 1);
      chk("drain_count", int'(count), 15 - i);
    end
    chk("drain_empty", int'(empty), 1);
    chk("drain_full", int'(full), 0);
    chk("drain_udf0", int'(underflow), 0);
    tick();
    chk("udf_set", int'(underflow), 1);
    chk("udf_rdv", int'(rd_valid), 0);
    chk("udf_dout", int'(dataout), 0);
    chk("udf_ovf_sticky", int'(overflow), 1);
    read_enb = 1'b0;

    // fill 5, then flush
    write_enb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      datain = 4'(9 + i);
      tick();
    end
    write_enb = 1'b0;
    chk("pre_flush_count", int'(count), 5);
    chk("pre_flush_udf", int'(underflow), 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_count", int'(count), 0);
    chk("flush_empty", int'(empty), 1);
    chk("flush_ovf", int'(overflow), 0);
    chk("flush_udf", int'(underflow), 0);
    chk("flush_dout", int'(dataout), 0);
    chk("flush_rdv", int'(rd_valid), 0);
    chk("flush_ae", int'(almost_empty), 1);

    // fill 0..15, then 20 cycles of read+write at full
    write_enb = 1'b1;
    for (int i = 0; i < 16; i++) begin
      datain = 4'(i);
      tick();
    end
    chk("full2_count", int'(count), 16);
    chk("full2_full", int'(full), 1);
    read_enb = 1'b1;
    datain   = 4'hA;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("rw_dout", int'(dataout), (k < 16) ? k : 10);
      chk("rw_rdv", int'(rd_valid), 1);
      chk("rw_count", int'(count), 16);
      chk("rw_full", int'(full), 1);
      chk("rw_ovf", int'(overflow), 0);
    end
    idle();

    // read+write while empty
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush2_dout", int'(dataout), 10);
    write_enb = 1'b1;
    read_enb  = 1'b1;
    datain    = 4'h5;
    tick();
    chk("e_rw_rdv", int'(rd_valid), 0);
    chk("e_rw_count", int'(count), 1);
    chk("e_rw_empty", int'(empty), 0);
    chk("e_rw_udf", int'(underflow), 1);
    chk("e_rw_dout", int'(dataout), 10);
    write_enb = 1'b0;
    tick();
    chk("e_rd_dout", int'(dataout), 5);
    chk("e_rd_rdv", int'(rd_valid), 1);
    chk("e_rd_count", int'(count), 0);
    chk("e_rd_empty", int'(empty), 1);
    read_enb = 1'b0;
    tick();
    chk("idle_rdv", int'(rd_valid), 0);
    chk("idle_dout", int'(dataout), 5);

    // fill 8, async reset between edges
    write_enb = 1'b1;
    datain    = 4'hC;
    for (int i = 0; i < 8; i++)
      tick();
    chk("pre_rst_count", int'(count), 8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", int'(count), 0);
    chk("arst_empty", int'(empty), 1);
    chk("arst_ae", int'(almost_empty), 1);
    chk("arst_dout", int'(dataout), 0);
    chk("arst_udf", int'(underflow), 0);
    read_enb = 1'b1;
    tick();
    chk("hold_count", int'(count), 0);
    chk("hold_rdv", int'(rd_valid), 0);
    chk("hold_dout", int'(dataout), 0);
    idle();
    rst_n = 1'b1;
    tick();
    write_enb = 1'b1;
    datain    = 4'h3;
    tick();
    write_enb = 1'b0;
    read_enb  = 1'b1;
    tick();
    read_enb = 1'b0;
    chk("post_rst_dout", int'(dataout), 3);
    chk("post_rst_rdv", int'(rd_valid), 1);
    chk("post_rst_count", int'(count), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
